// File: rtl/z80_page_ctrl_if.sv
// Bus bundle for the Z80 page-table controller: CPU translate/write port,
// configuration write port and the ready flag.
interface z80_page_ctrl_if;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack;
    logic [15:0] phys_addr;
    logic        cfg_req;
    logic [7:0]  cfg_idx;
    logic [7:0]  cfg_data;
    logic        cfg_ack;
    logic        ready;

    modport master (
        output cpu_req, cpu_addr, cpu_data, cfg_req, cfg_idx, cfg_data,
        input  cpu_ack, phys_addr, cfg_ack, ready
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_data, cfg_req, cfg_idx, cfg_data,
        output cpu_ack, phys_addr, cfg_ack, ready
    );
endinterface

// File: rtl/z80_page_ctrl.sv
// Page-table controller: clears the table after reset, then serves CPU
// translations/window writes and config writes through a round-robin arbiter.
module z80_page_ctrl #(
    parameter int SIZE = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    z80_page_ctrl_if.slave bus
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, RESP, WRITE} state_t;

    state_t      r_state;
    logic [7:0]  r_clr_cnt;
    logic [7:0]  r_idx;
    logic [7:0]  r_off;
    logic [7:0]  r_data;
    logic        r_last_cpu;
    logic        r_cpu_ack;
    logic        r_cfg_ack;
    logic        r_ready;
    logic [15:0] r_phys_addr;
    logic [7:0]  r_table [SIZE];

    logic          w_idx_ok;
    logic          w_pick_cpu;
    logic          w_cpu_wr;
    logic          w_we;
    logic [AW-1:0] w_wr_idx;
    logic [7:0]    w_wr_data;
    logic [7:0]    w_rd_data;

    // Entries at or beyond SIZE do not exist: writes drop, reads return zero.
    assign w_idx_ok   = {1'b0, r_idx} < 9'(SIZE);
    assign w_pick_cpu = bus.cpu_req && (!bus.cfg_req || !r_last_cpu);
    assign w_cpu_wr   = (bus.cpu_addr[15:8] == 8'h00);

    assign w_we      = (r_state == CLEAR) || ((r_state == WRITE) && w_idx_ok);
    assign w_wr_idx  = (r_state == CLEAR) ? r_clr_cnt[AW-1:0] : r_idx[AW-1:0];
    assign w_wr_data = (r_state == CLEAR) ? 8'h00 : r_data;
    assign w_rd_data = w_idx_ok ? r_table[r_idx[AW-1:0]] : 8'h00;

    // Single table port, no reset: contents are zeroed by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_table[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_clr_cnt   <= 8'h00;
            r_idx       <= 8'h00;
            r_off       <= 8'h00;
            r_data      <= 8'h00;
            r_last_cpu  <= 1'b1;
            r_cpu_ack   <= 1'b0;
            r_cfg_ack   <= 1'b0;
            r_ready     <= 1'b0;
            r_phys_addr <= 16'h0000;
        end else begin
            r_cpu_ack <= 1'b0;
            r_cfg_ack <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 8'd1;
                    if (r_clr_cnt == 8'(SIZE - 1)) begin
                        r_clr_cnt <= 8'h00;
                        r_ready   <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.cpu_req || bus.cfg_req) begin
                        r_last_cpu <= w_pick_cpu;
                        if (w_pick_cpu) begin
                            r_data <= bus.cpu_data;
                            r_off  <= bus.cpu_addr[7:0];
                            if (w_cpu_wr) begin
                                r_idx     <= bus.cpu_addr[7:0];
                                r_cpu_ack <= 1'b1;
                                r_state   <= WRITE;
                            end else begin
                                r_idx   <= bus.cpu_addr[15:8];
                                r_state <= LOOKUP;
                            end
                        end else begin
                            r_idx     <= bus.cfg_idx;
                            r_data    <= bus.cfg_data;
                            r_cfg_ack <= 1'b1;
                            r_state   <= WRITE;
                        end
                    end
                end
                // Acks are registered one state early so they are visible in RESP/WRITE.
                LOOKUP: begin
                    r_phys_addr <= {w_rd_data, r_off};
                    r_cpu_ack   <= 1'b1;
                    r_state     <= RESP;
                end
                RESP:    r_state <= IDLE;
                WRITE:   r_state <= IDLE;
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cfg_ack   = r_cfg_ack;
    assign bus.phys_addr = r_phys_addr;
    assign bus.ready     = r_ready;
endmodule
